// File: rtl/pipe_pkg.sv
// Shared types for the decode->execute hazard scheduler: forward selects,
// scheduler states and the in-flight destination scoreboard entry.
package pipe_pkg;

    localparam int DRAIN_CYCLES = 3;
    // Scoreboard register field is sized for the widest register file we build.
    localparam int SB_RD_BITS = 8;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic                  wr;
        logic [SB_RD_BITS-1:0] rd;
        logic                  ld;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

    // Youngest producer wins; a WB producer is already visible through the regfile.
    function automatic fwd_sel_t pick_fwd(input logic ex_hit, input logic mem_hit,
                                          input logic wb_hit);
        if (ex_hit)       return FWD_EXMEM;
        else if (mem_hit) return FWD_MEMWB;
        else if (wb_hit)  return FWD_RF;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipeline_hazard_scheduler_scoreboard.sv
// Three-deep EX/MEM/WB destination tracker with per-source match outputs.
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int REG_BITS = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ex_load,
    input  logic                wr_in,
    input  logic [REG_BITS-1:0] rd_in,
    input  logic                ld_in,
    input  logic [REG_BITS-1:0] src_rn,
    input  logic [REG_BITS-1:0] src_rm,
    input  logic                uses_rn,
    input  logic                uses_rm,
    output logic                ex_hit_rn,
    output logic                ex_hit_rm,
    output logic                mem_hit_rn,
    output logic                mem_hit_rm,
    output logic                wb_hit_rn,
    output logic                wb_hit_rm,
    output logic                ex_is_load
);

    sb_entry_t ex_q, ex_d;
    sb_entry_t mem_q, mem_d;
    sb_entry_t wb_q, wb_d;

    logic [SB_RD_BITS-1:0] rn_ext;
    logic [SB_RD_BITS-1:0] rm_ext;

    always_comb begin
        ex_d = SB_EMPTY;
        if (ex_load) begin
            ex_d.wr = wr_in;
            ex_d.rd = SB_RD_BITS'(rd_in);
            ex_d.ld = ld_in;
        end
        mem_d = ex_q;
        wb_d  = mem_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= SB_EMPTY;
            mem_q <= SB_EMPTY;
            wb_q  <= SB_EMPTY;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    always_comb begin
        rn_ext     = SB_RD_BITS'(src_rn);
        rm_ext     = SB_RD_BITS'(src_rm);
        ex_hit_rn  = uses_rn && ex_q.wr  && (ex_q.rd  == rn_ext);
        ex_hit_rm  = uses_rm && ex_q.wr  && (ex_q.rd  == rm_ext);
        mem_hit_rn = uses_rn && mem_q.wr && (mem_q.rd == rn_ext);
        mem_hit_rm = uses_rm && mem_q.wr && (mem_q.rd == rm_ext);
        wb_hit_rn  = uses_rn && wb_q.wr  && (wb_q.rd  == rn_ext);
        wb_hit_rm  = uses_rm && wb_q.wr  && (wb_q.rd  == rm_ext);
        ex_is_load = ex_q.ld;
    end

endmodule

// File: rtl/pipeline_hazard_scheduler.sv
// Decode->execute sequencing: hazard stalls/bubbles, operand forward selects
// and the halt-drain sequence.
//   state  | meaning
//   RUN    | normal issue, hazards evaluated every cycle
//   DRAIN  | HALT issued, bubbles while older work retires (DRAIN_CYCLES)
//   HALTED | pipeline empty and frozen until reset
module pipeline_hazard_scheduler
    import pipe_pkg::*;
#(
    parameter bit FORWARD_EN = 1'b1,
    parameter int REG_BITS   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dec_valid,
    input  logic [REG_BITS-1:0] dec_rn,
    input  logic [REG_BITS-1:0] dec_rm,
    input  logic                dec_uses_rn,
    input  logic                dec_uses_rm,
    input  logic                dec_write,
    input  logic [REG_BITS-1:0] dec_rd,
    input  logic                dec_is_load,
    input  logic                halt_req,
    output logic                stall_fd,
    output logic                bubble_de,
    output logic [1:0]          fwd_a_sel,
    output logic [1:0]          fwd_b_sel,
    output logic                halted
);

    sched_state_t state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;

    logic     stall;
    logic     halted_o;
    logic     sb_load;
    fwd_sel_t fwd_a, fwd_b;

    logic ex_hit_rn, ex_hit_rm, mem_hit_rn, mem_hit_rm, wb_hit_rn, wb_hit_rm;
    logic ex_is_load;

    hazard_scoreboard #(
        .REG_BITS (REG_BITS)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .ex_load    (sb_load),
        .wr_in      (dec_write),
        .rd_in      (dec_rd),
        .ld_in      (dec_is_load),
        .src_rn     (dec_rn),
        .src_rm     (dec_rm),
        .uses_rn    (dec_uses_rn),
        .uses_rm    (dec_uses_rm),
        .ex_hit_rn  (ex_hit_rn),
        .ex_hit_rm  (ex_hit_rm),
        .mem_hit_rn (mem_hit_rn),
        .mem_hit_rm (mem_hit_rm),
        .wb_hit_rn  (wb_hit_rn),
        .wb_hit_rm  (wb_hit_rm),
        .ex_is_load (ex_is_load)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        halted_o = 1'b0;
        fwd_a    = FWD_RF;
        fwd_b    = FWD_RF;
        unique case (state_q)
            RUN: begin
                if (dec_valid) begin
                    if (FORWARD_EN) begin
                        stall = ex_is_load && (ex_hit_rn || ex_hit_rm);
                        if (!stall) begin
                            fwd_a = pick_fwd(ex_hit_rn, mem_hit_rn, wb_hit_rn);
                            fwd_b = pick_fwd(ex_hit_rm, mem_hit_rm, wb_hit_rm);
                        end
                    end else begin
                        stall = ex_hit_rn || ex_hit_rm || mem_hit_rn || mem_hit_rm;
                    end
                    if (halt_req && !stall) begin
                        state_d = DRAIN;
                        cnt_d   = 2'd0;
                    end
                end
            end
            DRAIN: begin
                stall = 1'b1;
                if (cnt_q == 2'(DRAIN_CYCLES - 1)) begin
                    state_d = HALTED;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            HALTED: begin
                stall    = 1'b1;
                halted_o = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // The HALT instruction itself goes down the pipe as a no-op.
    assign sb_load = (state_q == RUN) && dec_valid && !stall && !halt_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_fd  = stall;
    assign bubble_de = stall;
    assign fwd_a_sel = fwd_a;
    assign fwd_b_sel = fwd_b;
    assign halted    = halted_o;

endmodule
